// File: rtl/seg_dec_pkg.sv
// Shared constants for the seven-segment scan decoder: digit count, segment codes, settle FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_dec_pkg;

   localparam int NUM_DIGITS = 8;

   // Run counter must be able to reach the largest legal stability threshold.
   localparam int CNT_MAX = 255;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   typedef enum logic [1:0] {
      CHANGE = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps an active-low seven-segment pattern to its hex nibble and flags unknown patterns.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module seg_pattern_decode
   import seg_dec_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       legal
);

   // Table lookup; anything outside the sixteen glyphs is reported as illegal.
   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (seg)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 32-bit word shown on a multiplexed 8-digit display from its an/seg lines; optional SEGDEC_ERR_CNT_EN adds err_count.
// Latency: a digit held for STABLE_CYCLES sampling edges commits on the following edge; value_valid/err appear one cycle later.
// Backpressure: none; passive observer, partial frames persist until completed or reset.
module seg_scan_decoder
   import seg_dec_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_DIGITS-1:0]     an,
   input  logic [6:0]                seg,
   output logic [4*NUM_DIGITS-1:0]   value,
   output logic                      value_valid,
   output logic [NUM_DIGITS-1:0]     digit_mask,
   output logic                      err
`ifdef SEGDEC_ERR_CNT_EN
   ,
   output logic [15:0]               err_count
`endif
);

   localparam int                IN_W       = NUM_DIGITS + 7;
   localparam logic [CNT_W-1:0]  STABLE_CNT = CNT_W'(STABLE_CYCLES);
   // Value the input registers take in reset: a blank phase, which never commits anything.
   localparam logic [IN_W-1:0]   IN_IDLE    = {{NUM_DIGITS{1'b1}}, 7'h7F};

   logic [IN_W-1:0]             in_d, in_q;
   logic [IN_W-1:0]             prev_d, prev_q;
   state_t                      state_d, state_q;
   logic [CNT_W-1:0]            cnt_d, cnt_q;
   logic                        commit;

   logic [NUM_DIGITS-1:0]       an_s;
   logic [6:0]                  seg_s;
   logic [3:0]                  nibble;
   logic                        legal;
   logic                        one_digit;

   logic [4*NUM_DIGITS-1:0]     shadow_d, shadow_q;
   logic [4*NUM_DIGITS-1:0]     value_d, value_q;
   logic [NUM_DIGITS-1:0]       mask_d, mask_q;
   logic                        valid_d, valid_q;
   logic                        err_d, err_q;

   assign in_d   = {an, seg};
   assign prev_d = in_q;
   assign an_s   = in_q[IN_W-1:7];
   assign seg_s  = in_q[6:0];

   // Input sampling plus a one-deep history so stability is judged on registered data only.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_q   <= IN_IDLE;
         prev_q <= IN_IDLE;
      end else begin
         in_q   <= in_d;
         prev_q <= prev_d;
      end
   end

   // Settle FSM state and run counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CHANGE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: any change restarts the run; a run reaching the threshold parks in HELD.
   // The counter is cleared (not set to 1) in reset so the sample taken during reset does not count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (in_q != prev_q) begin
         state_d = CHANGE;
         cnt_d   = CNT_W'(1);
      end else if (state_q != HELD) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = (cnt_d == STABLE_CNT) ? HELD : SETTLE;
      end
   end

   // FSM output: exactly one commit, on the edge that enters HELD.
   always_comb begin
      commit = (state_d == HELD) && (state_q != HELD);
   end

   seg_pattern_decode u_decode (
      .seg    (seg_s),
      .nibble (nibble),
      .legal  (legal)
   );

   assign one_digit = $onehot(~an_s);

   // Commit handling: store a legal single digit, publish the frame once all digits are in, flag bad samples.
   always_comb begin
      shadow_d = shadow_q;
      mask_d   = mask_q;
      value_d  = value_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      if (commit && (an_s != {NUM_DIGITS{1'b1}})) begin
         if (one_digit && legal) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (!an_s[i]) begin
                  shadow_d[4*i +: 4] = nibble;
               end
            end
            mask_d = mask_q | ~an_s;
            if (mask_d == {NUM_DIGITS{1'b1}}) begin
               value_d = shadow_d;
               valid_d = 1'b1;
               mask_d  = '0;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Shadow nibbles are deliberately not reset: value is only loaded from a complete frame.
   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
   end

   // Published word, frame progress and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         value_q <= value_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign value       = value_q;
   assign value_valid = valid_q;
   assign digit_mask  = mask_q;
   assign err         = err_q;

`ifdef SEGDEC_ERR_CNT_EN
   logic [15:0] err_cnt_d, err_cnt_q;

   // Saturating count of rejected samples, cleared only by reset.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised scoreboard bench for seg_scan_decoder against a per-cycle behavioural model of the display protocol.
// Latency: n/a (simulation only).
// Backpressure: n/a.
module tb_seg_scan_decoder;

   localparam int S = 4;
   localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  an  = 8'hFF;
   logic [6:0]  seg = 7'h7F;
   logic [31:0] value;
   logic        value_valid;
   logic [7:0]  digit_mask;
   logic        err;
`ifdef SEGDEC_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .seg         (seg),
      .value       (value),
      .value_valid (value_valid),
      .digit_mask  (digit_mask),
      .err         (err)
`ifdef SEGDEC_ERR_CNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   // ---------------- reference model ----------------
   logic [14:0] m_last;
   bit          m_last_vld = 0;
   int          m_run      = 0;
   logic [31:0] m_shadow   = '0;
   logic [7:0]  m_mask     = '0;
   int          m_errcnt   = 0;

   logic [31:0] q_val  [$];
   logic [7:0]  q_err  [$];
   logic [7:0]  q_mask [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int code_index(input logic [6:0] s);
      int r = -1;
      for (int k = 0; k < 16; k++) if (CODES[k] == s) r = k;
      return r;
   endfunction

   // What a stable pattern means at the display level.
   task automatic m_commit(input logic [7:0] a, input logic [6:0] s);
      logic [7:0] lit  = ~a;
      int         n    = code_index(s);
      logic [7:0] newm;
      if (a == 8'hFF) return;
      if ($countones(lit) == 1 && n >= 0) begin
         newm = m_mask | lit;
         for (int i = 0; i < 8; i++) if (lit[i]) m_shadow[4*i +: 4] = 4'(n);
         if (newm == 8'hFF) begin
            q_val.push_back(m_shadow);
            m_mask = 8'h00;
            q_mask.push_back(8'h00);
         end else if (newm != m_mask) begin
            m_mask = newm;
            q_mask.push_back(newm);
         end
      end else begin
         q_err.push_back(m_mask);
         if (m_errcnt < 65535) m_errcnt++;
      end
   endtask

   // Present a pattern for h sampling edges; the model counts consecutive identical samples.
   task automatic drive(input logic [7:0] a, input logic [6:0] s, input int h);
      for (int c = 0; c < h; c++) begin
         an  = a;
         seg = s;
         if (m_last_vld && m_last == {a, s}) m_run++;
         else begin
            m_last     = {a, s};
            m_last_vld = 1;
            m_run      = 1;
         end
         if (m_run == S) m_commit(a, s);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic blank(input int h);
      drive(8'hFF, 7'h7F, h);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      an         = 8'hFF;
      seg        = 7'h7F;
      m_last_vld = 0;
      m_run      = 0;
      if (m_mask != 8'h00) q_mask.push_back(8'h00);
      m_mask     = 8'h00;
      m_errcnt   = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic scan(input logic [31:0] w, input int h, input int bl, input bit shuffle);
      int         ord [8];
      int         t;
      int         j;
      logic [7:0] a;
      logic [3:0] nb;
      for (int i = 0; i < 8; i++) ord[i] = i;
      if (shuffle) begin
         for (int k = 7; k > 0; k--) begin
            j      = $urandom_range(0, k);
            t      = ord[k];
            ord[k] = ord[j];
            ord[j] = t;
         end
      end
      for (int k = 0; k < 8; k++) begin
         a  = ~(8'h01 << ord[k]);
         nb = w[4*ord[k] +: 4];
         drive(a, CODES[nb], h);
         if (bl > 0) blank(bl);
      end
   endtask

   // ---------------- monitor ----------------
   logic [7:0]  mask_prev    = 8'h00;
   int          mask_chg_cyc = 0;
   logic [31:0] mon_v;
   logic [7:0]  mon_m;

   always @(negedge clk) begin
      if (value_valid === 1'b1) begin
         if (q_val.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL value_valid_unexpected: got value %h with no frame expected", value);
         end else begin
            mon_v = q_val.pop_front();
            chk("frame_value", value, mon_v);
         end
      end
      if (err === 1'b1) begin
         if (q_err.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL err_unexpected: got err=1 expected 0 (mask %h)", digit_mask);
         end else begin
            mon_m = q_err.pop_front();
            chk("err_mask_kept", {24'h0, digit_mask}, {24'h0, mon_m});
         end
      end
      if (digit_mask !== mask_prev) begin
         mask_chg_cyc = cyc;
         if (q_mask.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mask_unexpected: got %h expected %h", digit_mask, mask_prev);
         end else begin
            mon_m = q_mask.pop_front();
            chk("mask_step", {24'h0, digit_mask}, {24'h0, mon_m});
         end
      end
      mask_prev = digit_mask;
   end

   // ---------------- stimulus ----------------
   int          t0;
   int          kind;
   int          h;
   int          di;
   logic [6:0]  s_ill;
   logic [7:0]  a_multi;
   int          b1;
   int          b2;

   initial begin
      do_reset();
      chk("rst_value", value, 32'h0);
      chk("rst_valid", {31'h0, value_valid}, 32'h0);
      chk("rst_mask", {24'h0, digit_mask}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
`ifdef SEGDEC_ERR_CNT_EN
      chk("rst_err_count", {16'h0, err_count}, 32'h0);
`endif

      // Three samples is one short of stable; four commits on the fifth edge.
      blank(3);
      drive(8'hFE, 7'h40, 3);
      blank(3);
      chk("glitch_mask", {24'h0, digit_mask}, 32'h0);
      t0 = cyc;
      drive(8'hFE, 7'h40, 4);
      blank(4);
      chk("commit_latency", mask_chg_cyc - t0, 5);

      // Ordered scan, no blanks.
      do_reset();
      scan(32'h1234ABCD, 8, 0, 0);
      blank(4);
      chk("scan_value", value, 32'h1234ABCD);

      // Two digits lit at once, then an illegal glyph followed by a legal one on digit 3.
      drive(8'hFC, 7'h40, 6);
      blank(4);
      drive(8'hF7, 7'h7F, 6);
      blank(4);
      drive(8'hF7, 7'h79, 6);
      blank(4);
      chk("digit3_set", {31'h0, digit_mask[3]}, 32'h1);

      // Reset in the middle of a frame, then a fresh shuffled frame.
      do_reset();
      for (int i = 0; i < 5; i++) drive(~(8'h01 << i), CODES[4'(i + 3)], 8);
      blank(3);
      do_reset();
      #1;
      chk("midframe_rst_mask", {24'h0, digit_mask}, 32'h0);
      chk("midframe_rst_value", value, 32'h0);
      scan(32'hDEADBEEF, 8, 0, 1);
      blank(4);
      chk("deadbeef_value", value, 32'hDEADBEEF);

      // Blank phases between every digit.
      scan(32'h00000000, 5, 3, 0);
      blank(4);
      chk("zero_frame_value", value, 32'h0);

      // Random mix of digits, blanks, glitches, errors and full frames.
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         h    = $urandom_range(1, 7);
         di   = $urandom_range(0, 7);
         if (kind <= 5) begin
            drive(~(8'h01 << di), CODES[4'($urandom_range(0, 15))], h);
         end else if (kind == 6) begin
            blank(h);
         end else if (kind == 7) begin
            b1 = $urandom_range(0, 7);
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            a_multi = ~((8'h01 << b1) | (8'h01 << b2) | ($urandom_range(0, 1) ? (8'h01 << di) : 8'h00));
            drive(a_multi, CODES[4'($urandom_range(0, 15))], h);
         end else if (kind == 8) begin
            s_ill = 7'($urandom_range(0, 127));
            while (code_index(s_ill) >= 0) s_ill = 7'($urandom_range(0, 127));
            drive(~(8'h01 << di), s_ill, h);
         end else begin
            scan($urandom, $urandom_range(4, 6), $urandom_range(0, 2), 1);
         end
      end
      blank(8);

      chk("pending_frames", q_val.size(), 0);
      chk("pending_errs", q_err.size(), 0);
      chk("pending_masks", q_mask.size(), 0);
      chk("final_mask", {24'h0, digit_mask}, {24'h0, m_mask});
`ifdef SEGDEC_ERR_CNT_EN
      chk("err_count", {16'h0, err_count}, 32'(m_errcnt));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the CPU top's seven-segment display driver: it samples the multiplexed `an`/`seg` outputs, waits for each digit to settle, decodes the segment pattern back to a hex nibble and rebuilds the 32-bit word being displayed. It is instantiated beside `Top` in simulation and on-board self-check builds. This gives benches and debug logic the displayed value directly, with no need to watch LEDs.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical input samples required before a digit is accepted; legal range 2..255.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `an` in 8: digit enables, active-low; bit i selects digit i, which is nibble `[4i+3:4i]`.
- `seg` in 7: segment lines, active-low, ordered {g,f,e,d,c,b,a}.
- `value` out 32: last completely reconstructed word. Reset 0.
- `value_valid` out 1: one-cycle pulse when `value` updates. Reset 0.
- `digit_mask` out 8: digits captured in the current frame. Reset 0.
- `err` out 1: one-cycle pulse on a rejected sample. Reset 0.
- `err_count` out 16: present only with `SEGDEC_ERR_CNT_EN`. Reset 0.

## Operation
- Inputs `an` and `seg` are registered once (`in_q`); all further decisions use `in_q`.
- Settle FSM has three states.
  - CHANGE: entered on reset and whenever `in_q` differs from the previous sample. The run counter is set to 1.
  - SETTLE: counter increments on each identical sample.
  - HELD: entered when the counter reaches `STABLE_CYCLES`, with exactly one commit on entry. The FSM stays in HELD until the sample changes, then returns to CHANGE.
- Commit rules:
  - `an` == 8'hFF (blank phase): no action and no error.
  - `an` has exactly one 0 bit at position i and `seg` is a legal pattern:
    - Nibble stored in shadow `[4i+3:4i]`; `digit_mask[i]` set.
    - Recapturing an already-set digit overwrites its nibble.
  - `an` has two or more 0 bits, or `seg` is illegal: `err` pulses. Shadow and mask are unchanged.
- Legal patterns (hex seg → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F. Every other code is illegal.
- Frame complete: a commit that makes `digit_mask` equal to 8'hFF does three things on the same edge.
  - Copies the shadow, including the new nibble, to `value`.
  - Pulses `value_valid`.
  - Clears `digit_mask` to 0.
- Digits may arrive in any order. No timeout exists: a partial frame persists until it is completed or reset.

## Timing
- Latency: if a pattern is present across sampling edges E1..E(S), with S = `STABLE_CYCLES`, then:
  - `in_q` matches it from edge E1+1.
  - The commit edge is E(S)+1.
  - `value`, `digit_mask` and `err` change on the commit edge; `value_valid` and `err` are high for the following cycle only.
- A glitch of fewer than S samples is discarded silently, and the counter restarts from the next sample.
- A pattern held indefinitely commits once only; a changed-then-restored pattern commits again.
- The shadow is not reset. `value` is only ever loaded from a full frame, so stale shadow data never appears at the output.
- `rst` mid-frame, on the next edge:
  - FSM returns to CHANGE.
  - Counter, `digit_mask`, `value`, `value_valid`, `err` and `err_count` are cleared.
  - The sample taken during reset does not count toward stability.

## Configuration
- `SEGDEC_ERR_CNT_EN` defined:
  - `err_count` port exists.
  - It increments by 1 on every `err` pulse and saturates at 16'hFFFF.
  - It is cleared only by `rst`.
- Not defined: the port and counter are absent; `err` behaviour is identical.

## Structure
- Package `seg_dec_pkg` holds:
  - `NUM_DIGITS` = 8.
  - The 16 segment-code constants.
  - FSM state enum {CHANGE, SETTLE, HELD}.
  - Counter width derived from 255.
- One sub-module, `seg_pattern_decode`: combinational, 7-bit `seg` in; 4-bit nibble and `legal` flag out. It is reused by the display-driver tests.

## Test plan
- 8-digit scan of 32'h1234ABCD with each digit held 8 cycles and S=4 → a single `value_valid` pulse and `value` = 32'h1234ABCD; `digit_mask` steps 01,03,…,7F, then 00.
- Digit held exactly 3 cycles with S=4 → no commit, `digit_mask` unchanged. Held 4 cycles → commit on the 5th edge.
- `an`=8'hFC with `seg`=7'h40 held 6 cycles → one `err` pulse, mask unchanged. With `SEGDEC_ERR_CNT_EN`, `err_count`=1.
- Illegal `seg`=7'h7F on digit 3 → `err` pulse. A later legal 7'h79 on digit 3 sets `digit_mask[3]`.
- `rst` asserted after 5 of 8 digits → `digit_mask`=0 next cycle. A following full scan of 32'hDEADBEEF yields exactly that value with no mixing.
- Blank phases (`an`=8'hFF, 3 cycles) interleaved between all digits → no `err`; frame of 32'h00000000 reconstructed.
